// File: rtl/common_pkg.sv
// Shared router types: tile transaction format, client index and credit depth.
package common_pkg;

    typedef struct packed {
        logic [3:0]  dst;
        logic [3:0]  src;
        logic [23:0] payload;
    } t_tile_trans;

    localparam int unsigned ROUTER_CREDITS = 4;

    typedef logic [1:0] t_client_idx;

endpackage

// File: rtl/router_credit_arb_rr_pick.sv
// Combinational find-first-set over a request vector, searching upward from
// start_i with wrap-around; returns one-hot grant, its index and a hit flag.
module router_rr_pick
    import common_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned IDX_W       = $clog2(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] req_i,
    input  logic [IDX_W-1:0]       start_i,
    output logic [NUM_CLIENTS-1:0] gnt_o,
    output logic [IDX_W-1:0]       idx_o,
    output logic                   found_o
);

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found_o = 1'b0;
        for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
            logic [IDX_W-1:0] j;
            j = IDX_W'((32'(start_i) + i) % NUM_CLIENTS);
            if (!found_o && req_i[j]) begin
                found_o  = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end

endmodule

// File: rtl/router_credit_arb.sv
// Output-port scheduler: burst-limited round-robin over the input FIFOs,
// every grant gated on downstream credits, one-cycle registered output link.
module router_credit_arb
    import common_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS = 4,
    parameter int unsigned CREDITS     = ROUTER_CREDITS,
    parameter int unsigned MAX_BURST   = 1,
    parameter int unsigned CNT_W       = $clog2(CREDITS + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic        [NUM_CLIENTS-1:0]        in_valid,
    input  t_tile_trans [NUM_CLIENTS-1:0]        in_data,
    output logic        [NUM_CLIENTS-1:0]        in_ready,
    output logic                                 out_valid,
    output t_tile_trans                          out_data,
    output logic        [$clog2(NUM_CLIENTS)-1:0] out_src,
    input  logic                                 credit_return,
    output logic        [CNT_W-1:0]              credit_cnt,
    output logic                                 credit_err
);

    localparam int unsigned IDX_W   = $clog2(NUM_CLIENTS);
    localparam int unsigned BURST_W = $clog2(MAX_BURST + 1);

    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               ov_q, ov_d;
    t_tile_trans        od_q, od_d;
    logic [IDX_W-1:0]   src_q, src_d;

    logic                   owner_keep;
    logic [IDX_W-1:0]       ptr_next;
    logic [IDX_W-1:0]       search_start;
    logic [NUM_CLIENTS-1:0] pick_gnt;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_found;
    logic                   grant;

    // Owner keeps the link while under its burst budget; otherwise the
    // search begins just past it, wrapping back to the owner if it is alone.
    assign owner_keep   = in_valid[ptr_q] && (burst_q < BURST_W'(MAX_BURST));
    assign ptr_next     = (ptr_q == IDX_W'(NUM_CLIENTS - 1)) ? '0 : ptr_q + 1'b1;
    assign search_start = owner_keep ? ptr_q : ptr_next;

    router_rr_pick #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .IDX_W       (IDX_W)
    ) u_pick (
        .req_i   (in_valid),
        .start_i (search_start),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    assign grant    = !rst && (cnt_q != '0) && pick_found;
    assign in_ready = grant ? pick_gnt : '0;

    always_comb begin
        ptr_d   = ptr_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ov_d    = grant;
        od_d    = od_q;
        src_d   = src_q;

        if (grant) begin
            od_d  = in_data[pick_idx];
            src_d = pick_idx;
            if (pick_idx == ptr_q) begin
                // Saturate: a lone owner past its budget keeps winning the wrap.
                if (burst_q != BURST_W'(MAX_BURST)) begin
                    burst_d = burst_q + 1'b1;
                end
            end else begin
                ptr_d   = pick_idx;
                burst_d = BURST_W'(1);
            end
        end

        if (grant && !credit_return) begin
            cnt_d = cnt_q - 1'b1;
        end else if (!grant && credit_return) begin
            if (cnt_q == CNT_W'(CREDITS)) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            burst_q <= '0;
            cnt_q   <= CNT_W'(CREDITS);
            err_q   <= 1'b0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            src_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            src_q   <= src_d;
        end
    end

    assign out_valid  = ov_q;
    assign out_data   = od_q;
    assign out_src    = src_q;
    assign credit_cnt = cnt_q;
    assign credit_err = err_q;

endmodule

// File: tb/tb_router_credit_arb.sv
// Bench for router_credit_arb: plain round-robin and burst-2 instances share
// stimulus; a rule-level model with a data queue checks both every cycle.
module tb_router_credit_arb;
    import common_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic [3:0]         in_valid;
    t_tile_trans [3:0]  in_data;
    logic               credit_return;

    logic [3:0]  rdy  [2];
    logic        ov   [2];
    t_tile_trans od   [2];
    logic [1:0]  osrc [2];
    logic [2:0]  cnt  [2];
    logic        err  [2];

    always #5 clk = ~clk;

    router_credit_arb #(.NUM_CLIENTS(4), .CREDITS(4), .MAX_BURST(1)) u_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[0]), .out_valid(ov[0]), .out_data(od[0]), .out_src(osrc[0]),
        .credit_return(credit_return), .credit_cnt(cnt[0]), .credit_err(err[0])
    );

    router_credit_arb #(.NUM_CLIENTS(4), .CREDITS(4), .MAX_BURST(2)) u_burst (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy[1]), .out_valid(ov[1]), .out_data(od[1]), .out_src(osrc[1]),
        .credit_return(credit_return), .credit_cnt(cnt[1]), .credit_err(err[1])
    );

    int errors = 0;
    int checks = 0;

    // Reference model state, per instance.
    int mb      [2] = '{1, 2};
    int m_ptr   [2];
    int m_burst [2];
    int m_cnt   [2];
    bit m_err   [2];
    bit m_ov    [2];

    typedef struct {
        int          src;
        t_tile_trans d;
    } exp_t;
    exp_t q0[$];
    exp_t q1[$];

    typedef struct {
        bit       rb;
        logic [3:0] v;
        bit       ret;
        logic [3:0] er;
        logic [3:0] eb;
        int       ecnt;
        bit       eerr;
    } vec_t;
    vec_t vt [31];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [3:0] v, input int k);
        if (m_cnt[k] == 0 || v == 4'b0) return -1;
        if (v[m_ptr[k]] && m_burst[k] < mb[k]) return m_ptr[k];
        for (int i = 1; i <= 4; i++) begin
            if (v[(m_ptr[k] + i) % 4]) return (m_ptr[k] + i) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ptr[k] = 0; m_burst[k] = 0; m_cnt[k] = 4; m_err[k] = 0; m_ov[k] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic step(input logic [3:0] v, input bit ret, input bit use_exp,
                        input logic [3:0] er, input logic [3:0] eb,
                        input int ecnt, input bit eerr);
        int   g [2];
        exp_t e;
        in_valid      = v;
        credit_return = ret;
        for (int i = 0; i < 4; i++) in_data[i] = t_tile_trans'($urandom);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            g[k] = pick(v, k);
            chk($sformatf("in_ready[%0d]", k), 32'(rdy[k]), (g[k] < 0) ? 32'd0 : (32'd1 << g[k]));
            chk($sformatf("out_valid[%0d]", k), 32'(ov[k]), 32'(m_ov[k]));
            if (ov[k] && m_ov[k]) begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("out_src[%0d]", k), 32'(osrc[k]), 32'(e.src));
                chk($sformatf("out_data[%0d]", k), od[k], e.d);
            end
            chk($sformatf("credit_cnt[%0d]", k), 32'(cnt[k]), 32'(m_cnt[k]));
            chk($sformatf("credit_err[%0d]", k), 32'(err[k]), 32'(m_err[k]));
        end
        if (use_exp) begin
            chk("tbl_ready_rr", 32'(rdy[0]), 32'(er));
            chk("tbl_ready_burst", 32'(rdy[1]), 32'(eb));
            chk("tbl_cnt", 32'(cnt[0]), 32'(ecnt));
            chk("tbl_err", 32'(err[0]), 32'(eerr));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            m_ov[k] = (g[k] >= 0);
            if (g[k] >= 0) begin
                e.src = g[k];
                e.d   = in_data[g[k]];
                if (k == 0) q0.push_back(e); else q1.push_back(e);
                if (g[k] == m_ptr[k]) m_burst[k]++;
                else begin m_ptr[k] = g[k]; m_burst[k] = 1; end
            end
            m_cnt[k] = m_cnt[k] - ((g[k] >= 0) ? 1 : 0) + (ret ? 1 : 0);
            if (m_cnt[k] > 4) begin m_cnt[k] = 4; m_err[k] = 1; end
        end
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("rst_ready[%0d]", k), 32'(rdy[k]), 32'd0);
                chk($sformatf("rst_ovalid[%0d]", k), 32'(ov[k]), 32'd0);
                chk($sformatf("rst_cnt[%0d]", k), 32'(cnt[k]), 32'd4);
                chk($sformatf("rst_err[%0d]", k), 32'(err[k]), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt = '{
            // round-robin vs burst-2, all valid, returns start after first grant
            '{1'b1, 4'b1111, 1'b0, 4'b0001, 4'b0001, 4, 1'b0},
            '{1'b0, 4'b1111, 1'b1, 4'b0010, 4'b0001, 3, 1'b0},
            '{1'b0, 4'b1111, 1'b1, 4'b0100, 4'b0010, 3, 1'b0},
            '{1'b0, 4'b1111, 1'b1, 4'b1000, 4'b0010, 3, 1'b0},
            '{1'b0, 4'b1111, 1'b1, 4'b0001, 4'b0100, 3, 1'b0},
            '{1'b0, 4'b1111, 1'b1, 4'b0010, 4'b0100, 3, 1'b0},
            '{1'b0, 4'b1111, 1'b1, 4'b0100, 4'b1000, 3, 1'b0},
            '{1'b0, 4'b1111, 1'b1, 4'b1000, 4'b1000, 3, 1'b0},
            // owner 1 drops valid after its first burst grant
            '{1'b1, 4'b1111, 1'b0, 4'b0001, 4'b0001, 4, 1'b0},
            '{1'b0, 4'b1111, 1'b1, 4'b0010, 4'b0001, 3, 1'b0},
            '{1'b0, 4'b1111, 1'b1, 4'b0100, 4'b0010, 3, 1'b0},
            '{1'b0, 4'b1101, 1'b1, 4'b1000, 4'b0100, 3, 1'b0},
            '{1'b0, 4'b1101, 1'b1, 4'b0001, 4'b0100, 3, 1'b0},
            // exhaustion, single return, simultaneous grant+return, overflow
            '{1'b1, 4'b1111, 1'b0, 4'b0001, 4'b0001, 4, 1'b0},
            '{1'b0, 4'b1111, 1'b0, 4'b0010, 4'b0001, 3, 1'b0},
            '{1'b0, 4'b1111, 1'b0, 4'b0100, 4'b0010, 2, 1'b0},
            '{1'b0, 4'b1111, 1'b0, 4'b1000, 4'b0010, 1, 1'b0},
            '{1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 0, 1'b0},
            '{1'b0, 4'b1111, 1'b1, 4'b0000, 4'b0000, 0, 1'b0},
            '{1'b0, 4'b1111, 1'b0, 4'b0001, 4'b0100, 1, 1'b0},
            '{1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 0, 1'b0},
            '{1'b0, 4'b1111, 1'b1, 4'b0000, 4'b0000, 0, 1'b0},
            '{1'b0, 4'b1111, 1'b1, 4'b0010, 4'b0100, 1, 1'b0},
            '{1'b0, 4'b1111, 1'b0, 4'b0100, 4'b1000, 1, 1'b0},
            '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 0, 1'b0},
            '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1, 1'b0},
            '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 2, 1'b0},
            '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 3, 1'b0},
            '{1'b0, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4, 1'b0},
            '{1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4, 1'b1},
            '{1'b0, 4'b1111, 1'b0, 4'b1000, 4'b1000, 4, 1'b1}
        };

        in_valid      = 4'b1111;
        credit_return = 1'b0;
        in_data       = '0;
        rst           = 1'b0;
        model_reset();
        #1;

        for (int r = 0; r < 31; r++) begin
            if (vt[r].rb) do_reset((r == 0) ? 10 : 2);
            step(vt[r].v, vt[r].ret, 1'b1, vt[r].er, vt[r].eb, vt[r].ecnt, vt[r].eerr);
        end

        // Asynchronous reset while a transaction is on the link and cnt == 1.
        do_reset(2);
        for (int c = 0; c < 3; c++) step(4'b1111, 1'b0, 1'b0, 4'b0, 4'b0, 0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("pre_rst_cnt[%0d]", k), 32'(cnt[k]), 32'd1);
            chk($sformatf("pre_rst_ovalid[%0d]", k), 32'(ov[k]), 32'd1);
        end
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("async_ovalid[%0d]", k), 32'(ov[k]), 32'd0);
            chk($sformatf("async_cnt[%0d]", k), 32'(cnt[k]), 32'd4);
            chk($sformatf("async_ready[%0d]", k), 32'(rdy[k]), 32'd0);
        end
        @(posedge clk);
        #1;
        do_reset(1);

        for (int c = 0; c < 400; c++) begin
            logic [3:0] v;
            bit         ret;
            v = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) v = 4'b1111;
            ret = (m_cnt[0] < 4) && ($urandom_range(0, 1) == 1);
            step(v, ret, 1'b0, 4'b0, 4'b0, 0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/router_credit_arb.md
Name: router_credit_arb

Overview:
- Output-port scheduler for the router.
- Shares one router output link between the four input FIFOs (north/south/east/west) of a fifo_arb-style buffer stage.
- Uses burst-limited round-robin arbitration.
- Gates every grant on credits for the downstream buffer; credits are returned by the neighbouring tile.
- Sits between the per-port FIFO pop interface and the output link register.

Parameters:
- NUM_CLIENTS, 4, number of requesting FIFOs.
- CREDITS, 4, downstream buffer depth; initial and maximum credit count.
- MAX_BURST, 1, consecutive grants the current owner may take before priority rotates (1 = plain round-robin).
- CNT_W, $clog2(CREDITS+1), credit counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  NUM_CLIENTS  FIFO i not empty; head entry valid.
- in_data  in  NUM_CLIENTS x t_tile_trans  FIFO head entries.
- in_ready  out  NUM_CLIENTS  one-hot grant; also the pop strobe to FIFO i.
- out_valid  out  1  registered transaction valid on the output link.
- out_data  out  t_tile_trans  registered transaction.
- out_src  out  $clog2(NUM_CLIENTS)  index of the granted client for out_data.
- credit_return  in  1  single-cycle pulse; downstream freed one entry.
- credit_cnt  out  CNT_W  current credit count.
- credit_err  out  1  sticky; credit returned while count == CREDITS.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - out_valid = 0, out_data = '0, out_src = 0.
  - credit_cnt = CREDITS, credit_err = 0.
  - rr pointer = 0, burst_cnt = 0.
  - in_ready = 0 while rst is high.
- Grant (combinational from registered state):
  - Grant only if credit_cnt != 0 and |in_valid.
  - If the owner (pointer) is valid and burst_cnt < MAX_BURST, grant the owner.
  - Otherwise grant the first valid client searching pointer+1, pointer+2, … modulo NUM_CLIENTS.
  - in_ready is exactly one-hot or zero; never asserted to a client whose in_valid = 0.
- Pointer and burst update on a grant to client g:
  - If g == pointer: burst_cnt += 1.
  - Else: pointer = g, burst_cnt = 1.
  - If burst_cnt reaches MAX_BURST and another client is valid, the next cycle's search starts at pointer+1.
  - If the owner drops valid: no update, and the search naturally moves on.
  - No grant: pointer and burst_cnt hold.
- Output: one-cycle latency.
  - out_valid(t+1) = grant(t); out_data and out_src are captured from the granted client.
  - out_valid is 0 in cycles following no grant; out_data holds its last value.
  - The downstream side has no ready; credits are the only flow control.
- Credit counter: next = cnt - grant + credit_return.
  - Simultaneous grant and return leaves the count unchanged.
  - A return arriving at count 0 enables a grant in the following cycle, not the same cycle.
  - Return at cnt == CREDITS with no grant: count stays CREDITS and credit_err is set (cleared only by rst).
  - Count never underflows, since no grant is issued at 0.
- Reset mid-operation: any in-flight out_valid is dropped and credits are restored to CREDITS. The integrator must reset the neighbouring tile together with this block.

Decomposition:
- t_tile_trans comes from common_pkg.
- Add to common_pkg:
  - localparam ROUTER_CREDITS = 4;
  - typedef t_client_idx logic [1:0];
- Natural sub-module: router_rr_pick, a combinational find-first-set starting from a pointer. Inputs are request vector and pointer; outputs are one-hot grant and index. It is reused by the burst logic.

Test Plan:
- Reset: hold rst 10 cycles with in_valid = 4'b1111 → in_ready = 0, out_valid = 0, credit_cnt = 4, credit_err = 0. After release, the first grant goes to client 0.
- Round-robin, MAX_BURST = 1, all valid, credit_return every cycle → grant order 0,1,2,3,0,1.
  - out_valid high every cycle, starting 1 cycle after the first grant.
  - out_src follows the same order; credit_cnt stays at 3 after the first grant.
- Burst, MAX_BURST = 2, all valid, credits abundant → grant order 0,0,1,1,2,2,3,3.
  - Dropping in_valid[1] after its first grant moves the next grant to client 2 with burst_cnt = 1.
- Credit exhaustion: all valid, no returns → exactly 4 grants, then in_ready = 0.
  - One credit_return pulse at cycle t → exactly one grant at t+1; credit_cnt goes 0 → 1 → 0.
- Simultaneous events: at credit_cnt = 1, a grant in the same cycle as credit_return leaves credit_cnt = 1.
  - Return with cnt = 4 and idle → cnt stays 4 and credit_err = 1 (sticky).
- Reset mid-traffic: assert rst while cnt = 1 and out_valid = 1 → out_valid drops immediately (async) and cnt = 4. Stream integrity is checked against a reference queue for every granted in_data.
